// File: rtl/cond_unit.sv
// ---------------------------------------------------------------------------
// cond_unit -- ARM-style condition evaluation with Thumb IT-block tracking.
//
// Holds the ALU flags register, evaluates the condition of each presented
// instruction against the flags as they were before the current edge, and
// registers the execute/squash decision one cycle later. While an IT block
// is active the instruction's own condition is ignored and the per-slot
// condition derived from the IT firstcond/mask is used instead.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst_n         synchronous active-low reset (highest priority)
//   alu_flags     [0:3] = [Z, C, N, V] from the ALU
//   flags_we      load alu_flags into flags_q at this edge
//   instr_valid   an instruction is presented this cycle
//   instr_cond    4-bit condition code of the presented instruction
//   it_start      presented instruction is an IT instruction
//   it_firstcond  IT base condition
//   it_mask       IT mask (lowest set bit gives block length)
//   flush         pipeline flush: abandons IT block, kills the decision
//   flags_q       [0:3] = [Z, C, N, V] current flags register
//   exec_valid    a registered decision is present
//   exec_ok       1 = execute, 0 = squash (meaningful when exec_valid=1)
//   in_it         IT block active (FSM state IT_ACTIVE)
//   it_left       remaining IT slots, 0..4
//   it_err        one-cycle pulse when an IT arrives inside an IT block
//
// Handshake: there is no back-pressure. An instruction is accepted on every
// edge where instr_valid=1 and flush=0; its decision appears on exec_ok with
// exec_valid=1 during the following cycle. exec_valid=0 otherwise.
// ---------------------------------------------------------------------------
module cond_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:3] alu_flags,
  input  logic       flags_we,
  input  logic       instr_valid,
  input  logic [3:0] instr_cond,
  input  logic       it_start,
  input  logic [3:0] it_firstcond,
  input  logic [3:0] it_mask,
  input  logic       flush,
  output logic [0:3] flags_q,
  output logic       exec_valid,
  output logic       exec_ok,
  output logic       in_it,
  output logic [2:0] it_left,
  output logic       it_err
);

  typedef enum logic {
    IDLE      = 1'b0,
    IT_ACTIVE = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] fc_q, fc_d;       // latched IT firstcond
  logic [3:1] mask_q, mask_d;   // latched IT mask; bit 0 only sets length
  logic [2:0] slot_q, slot_d;   // slot index i, 1..4
  logic [2:0] left_d;
  logic       ok_d;
  logic       err_d;
  logic       valid_d;
  logic [3:0] slot_cond;

  // Condition table evaluated on flags f = [Z, C, N, V].
  function automatic logic cond_pass(input logic [3:0] cond, input logic [0:3] f);
    logic z, c, n, v;
    z = f[0];
    c = f[1];
    n = f[2];
    v = f[3];
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = !c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = c & !z;
      4'b1001: cond_pass = !c | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      default: cond_pass = 1'b1;
    endcase
  endfunction

  // Block length from the lowest set mask bit; mask=0000 is never used here.
  function automatic logic [2:0] it_len(input logic [3:0] m);
    if (m[0])      it_len = 3'd4;
    else if (m[1]) it_len = 3'd3;
    else if (m[2]) it_len = 3'd2;
    else           it_len = 3'd1;
  endfunction

  // Slot condition {firstcond[3:1], b_i}.
  always_comb begin
    slot_cond = {fc_q[3:1], fc_q[0]};
    case (slot_q)
      3'd1:    slot_cond[0] = fc_q[0];
      3'd2:    slot_cond[0] = mask_q[3];
      3'd3:    slot_cond[0] = mask_q[2];
      default: slot_cond[0] = mask_q[1];
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fc_q       <= 4'd0;
      mask_q     <= 3'd0;
      slot_q     <= 3'd0;
      it_left    <= 3'd0;
      flags_q    <= 4'd0;
      exec_valid <= 1'b0;
      exec_ok    <= 1'b0;
      it_err     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fc_q       <= fc_d;
      mask_q     <= mask_d;
      slot_q     <= slot_d;
      it_left    <= left_d;
      exec_valid <= valid_d;
      exec_ok    <= ok_d;
      it_err     <= err_d;
      if (flags_we) flags_q <= alu_flags;
    end
  end

  // Next-state and decision logic. Decisions read flags_q, i.e. the
  // pre-edge flags, so a same-cycle flags_we never affects them.
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    mask_d  = mask_q;
    slot_d  = slot_q;
    left_d  = it_left;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    valid_d = instr_valid & !flush;
    if (flush) begin
      state_d = IDLE;
      left_d  = 3'd0;
    end else if (instr_valid) begin
      case (state_q)
        IDLE: begin
          if (it_start && (it_mask != 4'b0000)) begin
            ok_d    = 1'b1;
            fc_d    = it_firstcond;
            mask_d  = it_mask[3:1];
            slot_d  = 3'd1;
            left_d  = it_len(it_mask);
            state_d = IT_ACTIVE;
          end else begin
            ok_d = cond_pass(instr_cond, flags_q);
          end
        end
        default: begin
          // A nested IT is flagged but otherwise consumes a slot like any
          // other instruction; the running block is not reloaded.
          err_d  = it_start;
          ok_d   = cond_pass(slot_cond, flags_q);
          slot_d = slot_q + 3'd1;
          left_d = it_left - 3'd1;
          if (it_left == 3'd1) state_d = IDLE;
        end
      endcase
    end
  end

  // FSM output.
  always_comb begin
    in_it = (state_q == IT_ACTIVE);
  end

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [0:3] alu_flags;
  logic       flags_we;
  logic       instr_valid;
  logic [3:0] instr_cond;
  logic       it_start;
  logic [3:0] it_firstcond;
  logic [3:0] it_mask;
  logic       flush;
  logic [0:3] flags_q;
  logic       exec_valid;
  logic       exec_ok;
  logic       in_it;
  logic [2:0] it_left;
  logic       it_err;

  cond_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_flags    (alu_flags),
    .flags_we     (flags_we),
    .instr_valid  (instr_valid),
    .instr_cond   (instr_cond),
    .it_start     (it_start),
    .it_firstcond (it_firstcond),
    .it_mask      (it_mask),
    .flush        (flush),
    .flags_q      (flags_q),
    .exec_valid   (exec_valid),
    .exec_ok      (exec_ok),
    .in_it        (in_it),
    .it_left      (it_left),
    .it_err       (it_err)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: flags as [Z,C,N,V]; an IT block is a queue of pending
  // slot conditions, so in_it = non-empty and it_left = queue length.
  logic [0:3] m_flags;
  logic [3:0] exp_q[$];
  logic       m_ev, m_ok, m_err;

  function automatic logic ref_pass(input logic [3:0] cond, input logic [0:3] f);
    logic z, c, n, v;
    {z, c, n, v} = f;
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_step();
    logic b[4];
    int   len;
    if (!rst_n) begin
      m_flags = 4'b0000;
      m_ev = 0; m_ok = 0; m_err = 0;
      exp_q.delete();
      return;
    end
    m_err = 0;
    m_ev  = instr_valid && !flush;
    m_ok  = 0;
    if (flush) begin
      exp_q.delete();
    end else if (instr_valid) begin
      if (exp_q.size() == 0) begin
        if (it_start && it_mask != 4'b0000) begin
          m_ok = 1;
          b[0] = it_firstcond[0]; b[1] = it_mask[3]; b[2] = it_mask[2]; b[3] = it_mask[1];
          len = 0;
          for (int k = 0; k < 4; k++)
            if (len == 0 && it_mask[k]) len = 4 - k;
          for (int k = 0; k < len; k++) exp_q.push_back({it_firstcond[3:1], b[k]});
        end else begin
          m_ok = ref_pass(instr_cond, m_flags);
        end
      end else begin
        m_err = it_start;
        m_ok  = ref_pass(exp_q.pop_front(), m_flags);
      end
    end
    if (flags_we) m_flags = alu_flags;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    rst_n = 1; alu_flags = 4'b0000; flags_we = 0; instr_valid = 0;
    instr_cond = 4'd0; it_start = 0; it_firstcond = 4'd0; it_mask = 4'd0; flush = 0;
  endtask

  // One clock: advance the model with the driven inputs, then compare #1
  // after the rising edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("flags_q", 8'(flags_q), 8'(m_flags));
    check("exec_valid", 8'(exec_valid), 8'(m_ev));
    if (m_ev) check("exec_ok", 8'(exec_ok), 8'(m_ok));
    check("in_it", 8'(in_it), 8'(exp_q.size() != 0));
    check("it_left", 8'(it_left), 8'(exp_q.size()));
    check("it_err", 8'(it_err), 8'(m_err));
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    cycle();
    cycle();
    rst_n = 1;
  endtask

  task automatic set_flags(input logic [0:3] f);
    clear_inputs();
    flags_we = 1; alu_flags = f;
    cycle();
  endtask

  task automatic instr(input logic [3:0] cond);
    clear_inputs();
    instr_valid = 1; instr_cond = cond;
    cycle();
  endtask

  task automatic it_instr(input logic [3:0] fc, input logic [3:0] m);
    clear_inputs();
    instr_valid = 1; it_start = 1; it_firstcond = fc; it_mask = m;
    cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    do_reset();
    check("rst_flags", 8'(flags_q), 8'h0);
    check("rst_exec_ok", 8'(exec_ok), 8'h0);
    check("rst_in_it", 8'(in_it), 8'h0);

    // Flags load then EQ / NE.
    set_flags(4'b1000);
    instr(4'b0000); check("eq_z1", 8'(exec_ok), 8'h1);
    instr(4'b0001); check("ne_z1", 8'(exec_ok), 8'h0);

    // Same-cycle flags_we does not affect the decision.
    do_reset();
    clear_inputs();
    flags_we = 1; alu_flags = 4'b1000; instr_valid = 1; instr_cond = 4'b0000;
    cycle();
    check("eq_old_flags", 8'(exec_ok), 8'h0);

    // N=1, V=0 signed compares.
    set_flags(4'b0010);
    instr(4'b1010); check("ge_nv", 8'(exec_ok), 8'h0);
    instr(4'b1011); check("lt_nv", 8'(exec_ok), 8'h1);
    instr(4'b1101); check("le_nv", 8'(exec_ok), 8'h1);
    instr(4'b1100); check("gt_nv", 8'(exec_ok), 8'h0);

    // IT EQ, mask 0100 (two slots), Z=1.
    set_flags(4'b1000);
    it_instr(4'b0000, 4'b0100);
    check("it_ok", 8'(exec_ok), 8'h1);
    check("it_left_2", 8'(it_left), 8'd2);
    instr(4'b0001); check("slot1_eq", 8'(exec_ok), 8'h1);
    instr(4'b0001); check("slot2_eq", 8'(exec_ok), 8'h1);
    check("it_done", 8'(in_it), 8'h0);
    instr(4'b0001); check("after_it_ne", 8'(exec_ok), 8'h0);

    // Nested IT in slot 2 of a three-slot block.
    it_instr(4'b0000, 4'b1010);
    check("it3_left", 8'(it_left), 8'd3);
    instr(4'b0000);
    check("it3_left_2", 8'(it_left), 8'd2);
    it_instr(4'b0001, 4'b0001);
    check("nested_err", 8'(it_err), 8'h1);
    check("nested_left", 8'(it_left), 8'd1);
    clear_inputs();
    cycle();
    check("err_clear", 8'(it_err), 8'h0);
    check("hold_left", 8'(it_left), 8'd1);
    instr(4'b0000);
    check("it3_done", 8'(in_it), 8'h0);

    // Flush mid-block, then reset mid-block.
    it_instr(4'b0000, 4'b0001);
    instr(4'b0000);
    check("it4_left_3", 8'(it_left), 8'd3);
    clear_inputs();
    flush = 1; instr_valid = 1; it_start = 1;
    cycle();
    check("flush_in_it", 8'(in_it), 8'h0);
    check("flush_valid", 8'(exec_valid), 8'h0);
    check("flush_left", 8'(it_left), 8'd0);
    set_flags(4'b0110);
    it_instr(4'b0000, 4'b0001);
    instr(4'b0000);
    clear_inputs();
    rst_n = 0; flags_we = 1; alu_flags = 4'b1111; instr_valid = 1; flush = 1;
    cycle();
    check("rst2_flags", 8'(flags_q), 8'h0);
    check("rst2_valid", 8'(exec_valid), 8'h0);
    check("rst2_ok", 8'(exec_ok), 8'h0);
    check("rst2_in_it", 8'(in_it), 8'h0);
    check("rst2_left", 8'(it_left), 8'd0);
    check("rst2_err", 8'(it_err), 8'h0);

    // Randomized traffic against the model.
    for (int t = 0; t < 3000; t++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      flush        = ($urandom_range(0, 15) == 0);
      flags_we     = ($urandom_range(0, 3) == 0);
      alu_flags    = 4'($urandom_range(0, 15));
      instr_valid  = ($urandom_range(0, 3) != 0);
      instr_cond   = 4'($urandom_range(0, 15));
      it_start     = ($urandom_range(0, 5) == 0);
      it_firstcond = 4'($urandom_range(0, 15));
      it_mask      = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
